// File: rtl/shared_pipe_arbiter.sv
// Arbitrates NUM_REQ requesters onto one fixed-latency pipeline and routes each result back by tag.
// Define ARB_ROUND_ROBIN_EN for rotating-pointer arbitration; otherwise the lowest index wins.
module shared_pipe_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int PIPE_LATENCY = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    output logic [NUM_REQ-1:0]              o_req_ready,
    input  logic                            i_stall,
    output logic [DATA_WIDTH-1:0]           o_pipe_data,
    output logic                            o_pipe_valid,
    input  logic [DATA_WIDTH-1:0]           i_pipe_data,
    input  logic                            i_pipe_valid,
    output logic [DATA_WIDTH-1:0]           o_resp_data,
    output logic [NUM_REQ-1:0]              o_resp_valid,
    input  logic                            i_clear_stats,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    o_grant_count,
    output logic                            o_tag_error
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int SW   = ID_W + 1;

    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       grant_id;
    logic                  grant_any;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [ID_W-1:0]       issue_id;
    logic [PIPE_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]       tag_id [PIPE_LATENCY];
    logic [CNT_WIDTH-1:0]  cnt [NUM_REQ];

    // Search starts at the pointer and wraps modulo NUM_REQ; first valid requester wins.
    always_comb begin : arb
        logic [SW-1:0]   sum;
        logic [ID_W-1:0] idx;
        grant_any = 1'b0;
        grant_id  = '0;
        sum       = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
            idx = sum[ID_W-1:0];
            if (!grant_any && i_req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    assign xfer = grant_any && !i_stall && !reset;

    always_comb begin
        o_req_ready = '0;
        if (xfer) o_req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++)
            if (grant_id == ID_W'(k)) grant_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (xfer)
            ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_pipe_valid <= 1'b0;
            o_pipe_data  <= '0;
            issue_id     <= '0;
        end else begin
            o_pipe_valid <= xfer;
            if (xfer) begin
                o_pipe_data <= grant_data;
                issue_id    <= grant_id;
            end
        end
    end

    // Tag line output lines up with i_pipe_valid for the issue PIPE_LATENCY cycles earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < PIPE_LATENCY; i++) tag_id[i] <= '0;
        end else begin
            tag_v[0]  <= o_pipe_valid;
            tag_id[0] <= issue_id;
            for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_resp_valid <= '0;
            o_resp_data  <= '0;
            o_tag_error  <= 1'b0;
        end else begin
            o_resp_valid <= '0;
            if (i_pipe_valid && tag_v[PIPE_LATENCY-1]) begin
                o_resp_valid[tag_id[PIPE_LATENCY-1]] <= 1'b1;
                o_resp_data <= i_pipe_data;
            end
            if (i_pipe_valid != tag_v[PIPE_LATENCY-1]) o_tag_error <= 1'b1;
        end
    end

    // A transfer coinciding with a clear leaves that counter at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (xfer && grant_id == ID_W'(k)) begin
                    if (i_clear_stats)
                        cnt[k] <= CNT_WIDTH'(1);
                    else if (cnt[k] != '1)
                        cnt[k] <= cnt[k] + 1'b1;
                end else if (i_clear_stats) begin
                    cnt[k] <= '0;
                end
            end
        end
    end

    always_comb begin
        o_grant_count = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++)
            o_grant_count[k*CNT_WIDTH +: CNT_WIDTH] = cnt[k];
    end

endmodule

// File: tb/tb_shared_pipe_arbiter.sv
// Directed bench for shared_pipe_arbiter with an identity PIPE_LATENCY-deep pipeline model.
module tb_shared_pipe_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int PL = 3;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR*DW-1:0] i_req_data;
    logic [NR-1:0]   i_req_valid;
    logic [NR-1:0]   o_req_ready;
    logic            i_stall;
    logic [DW-1:0]   o_pipe_data;
    logic            o_pipe_valid;
    logic [DW-1:0]   i_pipe_data;
    logic            i_pipe_valid;
    logic [DW-1:0]   o_resp_data;
    logic [NR-1:0]   o_resp_valid;
    logic            i_clear_stats;
    logic [NR*CW-1:0] o_grant_count;
    logic            o_tag_error;

    logic            inject;
    logic [PL-1:0]   pv = '0;
    logic [DW-1:0]   pd [PL];

    int errors = 0;
    int checks = 0;

    shared_pipe_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .PIPE_LATENCY(PL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req_data(i_req_data), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_stall(i_stall),
        .o_pipe_data(o_pipe_data), .o_pipe_valid(o_pipe_valid),
        .i_pipe_data(i_pipe_data), .i_pipe_valid(i_pipe_valid),
        .o_resp_data(o_resp_data), .o_resp_valid(o_resp_valid),
        .i_clear_stats(i_clear_stats), .o_grant_count(o_grant_count),
        .o_tag_error(o_tag_error)
    );

    always #5 clk = ~clk;

    // Pipeline model is deliberately not reset so in-flight items still return after a DUT reset.
    always @(posedge clk) begin
        pv    <= {pv[PL-2:0], o_pipe_valid};
        pd[0] <= o_pipe_data;
        for (int i = 1; i < PL; i++) pd[i] <= pd[i-1];
    end

    always_comb begin
        i_pipe_valid = pv[PL-1] | inject;
        i_pipe_data  = inject ? 16'hDEAD : pd[PL-1];
    end

    function automatic int exp_grant(input int c);
`ifdef ARB_ROUND_ROBIN_EN
        return c % NR;
`else
        return 0;
`endif
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        i_req_valid = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        i_req_valid = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; i_stall = 1'b0; i_clear_stats = 1'b0; inject = 1'b0;
        i_req_data = '0; i_req_valid = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", o_req_ready); end
        checks++; if (o_pipe_valid !== 1'b0) begin errors++; $display("FAIL reset_pipe_valid: got %b expected 0", o_pipe_valid); end
        checks++; if (o_pipe_data !== 16'h0) begin errors++; $display("FAIL reset_pipe_data: got %h expected 0000", o_pipe_data); end
        checks++; if (o_resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0000", o_resp_valid); end
        checks++; if (o_resp_data !== 16'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0000", o_resp_data); end
        checks++; if (o_tag_error !== 1'b0) begin errors++; $display("FAIL reset_tag_error: got %b expected 0", o_tag_error); end
        checks++; if (o_grant_count !== 16'h0) begin errors++; $display("FAIL reset_counts: got %h expected 0000", o_grant_count); end
        i_req_valid = '0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_issue();
        @(negedge clk);
        i_req_data[2*DW +: DW] = 16'h00A5;
        i_req_valid = 4'b0100;
        #1;
        checks++; if (o_req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", o_req_ready); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) i_req_valid = '0;
            #1;
            if (c == 1) begin
                checks++; if (o_pipe_valid !== 1'b1) begin errors++; $display("FAIL single_pipe_valid: got %b expected 1", o_pipe_valid); end
                checks++; if (o_pipe_data !== 16'h00A5) begin errors++; $display("FAIL single_pipe_data: got %h expected 00a5", o_pipe_data); end
                checks++; if (o_grant_count[2*CW +: CW] !== 4'd1) begin errors++; $display("FAIL single_count2: got %0d expected 1", o_grant_count[2*CW +: CW]); end
            end else if (c == 5) begin
                checks++; if (o_resp_valid !== 4'b0100) begin errors++; $display("FAIL single_resp_valid: got %b expected 0100", o_resp_valid); end
                checks++; if (o_resp_data !== 16'h00A5) begin errors++; $display("FAIL single_resp_data: got %h expected 00a5", o_resp_data); end
            end else begin
                checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL single_resp_early_late c=%0d: got %b expected 0000", c, o_resp_valid); end
            end
        end
        idle(2);
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_oh;
        logic [CW-1:0] exp_cnt;
        apply_reset();
        for (int k = 0; k < NR; k++) i_req_data[k*DW +: DW] = 16'h0100 + 16'(k);
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            i_req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                exp_oh = 4'(1 << exp_grant(c));
                checks++; if (o_req_ready !== exp_oh) begin errors++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, o_req_ready, exp_oh); end
            end
            if (c >= 1 && c <= 8) begin
                checks++; if (o_pipe_valid !== 1'b1 || o_pipe_data !== 16'h0100 + 16'(exp_grant(c-1)))
                    begin errors++; $display("FAIL rr_issue c=%0d: got %b/%h expected 1/%h", c, o_pipe_valid, o_pipe_data, 16'h0100 + 16'(exp_grant(c-1))); end
            end
            if (c >= 5) begin
                exp_oh = 4'(1 << exp_grant(c-5));
                checks++; if (o_resp_valid !== exp_oh || o_resp_data !== 16'h0100 + 16'(exp_grant(c-5)))
                    begin errors++; $display("FAIL rr_resp c=%0d: got %b/%h expected %b/%h", c, o_resp_valid, o_resp_data, exp_oh, 16'h0100 + 16'(exp_grant(c-5))); end
            end
        end
        for (int k = 0; k < NR; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_cnt = 4'd2;
`else
            exp_cnt = (k == 0) ? 4'd8 : 4'd0;
`endif
            checks++; if (o_grant_count[k*CW +: CW] !== exp_cnt) begin errors++; $display("FAIL rr_count%0d: got %0d expected %0d", k, o_grant_count[k*CW +: CW], exp_cnt); end
        end
    endtask

    task automatic test_stall();
        logic [NR-1:0] exp_oh;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            i_req_valid = 4'b1010;
            i_stall = 1'b1;
            #1;
            checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready s=%0d: got %b expected 0000", s, o_req_ready); end
            checks++; if (o_pipe_valid !== 1'b0) begin errors++; $display("FAIL stall_pipe_valid s=%0d: got %b expected 0", s, o_pipe_valid); end
        end
        @(negedge clk);
        i_stall = 1'b0;
        #1;
        checks++; if (o_req_ready !== 4'b0010) begin errors++; $display("FAIL stall_release_ready: got %b expected 0010", o_req_ready); end
        @(negedge clk);
        #1;
        checks++; if (o_pipe_valid !== 1'b1 || o_pipe_data !== 16'h0101) begin errors++; $display("FAIL stall_release_issue: got %b/%h expected 1/0101", o_pipe_valid, o_pipe_data); end
`ifdef ARB_ROUND_ROBIN_EN
        exp_oh = 4'b1000;
`else
        exp_oh = 4'b0010;
`endif
        checks++; if (o_req_ready !== exp_oh) begin errors++; $display("FAIL stall_second_ready: got %b expected %b", o_req_ready, exp_oh); end
        @(negedge clk);
        idle(6);
    endtask

    task automatic test_counter_saturation();
        apply_reset();
        i_req_valid = 4'b0001;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            #1;
            if (n == 14) begin
                checks++; if (o_grant_count[0 +: CW] !== 4'd14) begin errors++; $display("FAIL cnt_14: got %0d expected 14", o_grant_count[0 +: CW]); end
            end
            if (n == 15 || n == 20) begin
                checks++; if (o_grant_count[0 +: CW] !== 4'd15) begin errors++; $display("FAIL cnt_sat n=%0d: got %0d expected 15", n, o_grant_count[0 +: CW]); end
            end
        end
        i_req_valid = '0;
        @(negedge clk);
        i_req_valid = 4'b0001;
        i_clear_stats = 1'b1;
        @(negedge clk);
        i_req_valid = '0;
        i_clear_stats = 1'b0;
        #1;
        checks++; if (o_grant_count[0 +: CW] !== 4'd1) begin errors++; $display("FAIL cnt_clear_with_grant: got %0d expected 1", o_grant_count[0 +: CW]); end
        @(negedge clk);
        i_clear_stats = 1'b1;
        @(negedge clk);
        i_clear_stats = 1'b0;
        #1;
        checks++; if (o_grant_count !== 16'h0) begin errors++; $display("FAIL cnt_clear: got %h expected 0000", o_grant_count); end
        idle(6);
    endtask

    task automatic test_tag_error();
        #1;
        checks++; if (o_tag_error !== 1'b0) begin errors++; $display("FAIL tag_err_before: got %b expected 0", o_tag_error); end
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #1;
        checks++; if (o_tag_error !== 1'b1) begin errors++; $display("FAIL tag_err_set: got %b expected 1", o_tag_error); end
        checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL tag_err_resp: got %b expected 0000", o_resp_valid); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (o_tag_error !== 1'b1) begin errors++; $display("FAIL tag_err_sticky: got %b expected 1", o_tag_error); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        i_req_valid = 4'b0001;
        @(negedge clk);
        #1;
        checks++; if (o_pipe_valid !== 1'b1) begin errors++; $display("FAIL mid_issue: got %b expected 1", o_pipe_valid); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: got %b expected 0000", o_req_ready); end
        checks++; if (o_pipe_valid !== 1'b0 || o_pipe_data !== 16'h0) begin errors++; $display("FAIL mid_pipe: got %b/%h expected 0/0000", o_pipe_valid, o_pipe_data); end
        checks++; if (o_resp_valid !== 4'b0 || o_resp_data !== 16'h0) begin errors++; $display("FAIL mid_resp: got %b/%h expected 0000/0000", o_resp_valid, o_resp_data); end
        checks++; if (o_tag_error !== 1'b0) begin errors++; $display("FAIL mid_tag_error: got %b expected 0", o_tag_error); end
        checks++; if (o_grant_count !== 16'h0) begin errors++; $display("FAIL mid_counts: got %h expected 0000", o_grant_count); end
        @(negedge clk);
        reset = 1'b0;
        i_req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL mid_no_resp c=%0d: got %b expected 0000", c, o_resp_valid); end
        end
        checks++; if (o_tag_error !== 1'b1) begin errors++; $display("FAIL mid_orphan_error: got %b expected 1", o_tag_error); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_round_robin();
        test_stall();
        test_counter_saturation();
        test_tag_error();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
